copy_engine_cmpl_notify: RTL and testbench

Completion-notification responder for the copy engine's write side. It consumes the write command from the CSR block and per-command completion pulses from the write engine. It reports progress to the host in one of two ways: a 64-bit memory status write of the running completion count to `mem_status_addr`, or an interrupt on `intr_id` followed by a wait for the host's `intr_ack`. It sits between the write engine and the host-channel write/interrupt arbiter.

---
 rtl/copy_engine_pkg.sv | 26 ++
 rtl/copy_engine_req_hold.sv | 34 +++
 rtl/copy_engine_cmpl_notify.sv | 137 +++++++++++++
 tb/tb_copy_engine_cmpl_notify.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/copy_engine_pkg.sv
// Shared types for the copy engine write-side completion path.
package copy_engine_pkg;

  localparam int unsigned CMPL_CNT_BITS = 64;
  localparam int unsigned INTR_ID_BITS  = 4;

  typedef logic [INTR_ID_BITS-1:0]  t_cmd_intr_id;
  typedef logic [CMPL_CNT_BITS-1:0] t_cmpl_cnt;

  // Write command as presented by the CSR block.
  typedef struct packed {
    logic         enable;
    t_cmd_intr_id intr_id;
    logic         intr_ack;
    logic         use_mem_status;
    logic [63:0]  mem_status_addr;
  } t_wr_cmd;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM_REQ,
    ST_INTR_REQ,
    ST_INTR_WAIT_ACK
  } t_cmpl_state;

endpackage

// File: rtl/copy_engine_req_hold.sv
// Valid/ready request register: captures a payload on load and holds
// valid plus payload stable until the consumer accepts it.
module copy_engine_req_hold #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_payload,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_payload
);

  logic         r_valid;
  logic [W-1:0] r_payload;

  // Load raises valid with a fresh payload; a handshake drops valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_payload <= i_payload;
    end else if (r_valid && i_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_payload = r_payload;

endmodule

// File: rtl/copy_engine_cmpl_notify.sv
// Completion-notification responder: counts write completions and reports
// progress by a memory status write or by an interrupt with host ack.
module copy_engine_cmpl_notify
  import copy_engine_pkg::*;
#(
  parameter int unsigned CNT_BITS = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  t_wr_cmd             wr_cmd,
  input  logic                cmpl_valid,
  output logic                status_wr_valid,
  input  logic                status_wr_ready,
  output logic [63:0]         status_wr_addr,
  output logic [CNT_BITS-1:0] status_wr_data,
  output logic                intr_valid,
  input  logic                intr_ready,
  output t_cmd_intr_id        intr_id_out,
  output logic [CNT_BITS-1:0] cmds_done,
  output logic                busy
);

  localparam int unsigned MEM_W  = 64 + CNT_BITS;
  localparam int unsigned INTR_W = $bits(t_cmd_intr_id);

  t_cmpl_state         r_state;
  t_cmpl_state         w_next_state;
  logic                r_enable_d;
  logic [CNT_BITS-1:0] r_cmds_done;
  logic [CNT_BITS-1:0] r_reported;
  logic                w_enable_rise;
  logic                w_owed;
  logic                w_mem_load;
  logic                w_intr_load;
  logic                w_mem_hs;
  logic [MEM_W-1:0]    w_mem_payload;
  logic [INTR_W-1:0]   w_intr_payload;

  assign w_enable_rise = wr_cmd.enable && !r_enable_d;
  assign w_owed        = (r_cmds_done != r_reported);
  assign w_mem_hs      = status_wr_valid && status_wr_ready;

  // Enable edge detector and running completion counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable_d  <= 1'b0;
      r_cmds_done <= '0;
    end else begin
      r_enable_d <= wr_cmd.enable;
      if (w_enable_rise)
        r_cmds_done <= '0;
      else if (wr_cmd.enable && cmpl_valid)
        r_cmds_done <= r_cmds_done + 1'b1;
    end
  end

  // Last delivered count; cleared with the counter so a fresh enable owes nothing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_reported <= '0;
    else if (w_enable_rise)
      r_reported <= '0;
    else if (w_intr_load)
      r_reported <= r_cmds_done;
    else if (r_state == ST_MEM_REQ && w_mem_hs)
      r_reported <= status_wr_data;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next_state;
  end

  // Next-state and request launch. Launch is suppressed on the enable rising
  // edge because the counter and reported value are being cleared that cycle.
  always_comb begin
    w_next_state = r_state;
    w_mem_load   = 1'b0;
    w_intr_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (wr_cmd.enable && !w_enable_rise && w_owed) begin
          if (wr_cmd.use_mem_status) begin
            w_mem_load   = 1'b1;
            w_next_state = ST_MEM_REQ;
          end else begin
            w_intr_load  = 1'b1;
            w_next_state = ST_INTR_REQ;
          end
        end
      end
      ST_MEM_REQ: begin
        if (w_mem_hs)
          w_next_state = ST_IDLE;
      end
      ST_INTR_REQ: begin
        if (intr_valid && intr_ready)
          w_next_state = ST_INTR_WAIT_ACK;
      end
      ST_INTR_WAIT_ACK: begin
        if (wr_cmd.intr_ack || !wr_cmd.enable)
          w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  copy_engine_req_hold #(.W(MEM_W)) u_mem_hold (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_mem_load),
    .i_payload ({wr_cmd.mem_status_addr, r_cmds_done}),
    .i_ready   (status_wr_ready),
    .o_valid   (status_wr_valid),
    .o_payload (w_mem_payload)
  );

  copy_engine_req_hold #(.W(INTR_W)) u_intr_hold (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_intr_load),
    .i_payload (wr_cmd.intr_id),
    .i_ready   (intr_ready),
    .o_valid   (intr_valid),
    .o_payload (w_intr_payload)
  );

  assign status_wr_addr = w_mem_payload[CNT_BITS +: 64];
  assign status_wr_data = w_mem_payload[CNT_BITS-1:0];
  assign intr_id_out    = w_intr_payload;
  assign cmds_done      = r_cmds_done;
  assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_copy_engine_cmpl_notify.sv
// Self-checking bench for copy_engine_cmpl_notify with a handshake scoreboard.
module tb_copy_engine_cmpl_notify;
  import copy_engine_pkg::*;

  localparam int unsigned CNT_BITS = 64;

  logic                clk = 1'b0;
  logic                reset_n;
  t_wr_cmd             wr_cmd;
  logic                cmpl_valid;
  logic                status_wr_valid;
  logic                status_wr_ready;
  logic [63:0]         status_wr_addr;
  logic [CNT_BITS-1:0] status_wr_data;
  logic                intr_valid;
  logic                intr_ready;
  t_cmd_intr_id        intr_id_out;
  logic [CNT_BITS-1:0] cmds_done;
  logic                busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_mem  = 0;
  int n_intr = 0;

  logic [63+CNT_BITS:0] exp_mem_q [$];
  t_cmd_intr_id         exp_intr_q[$];
  int                   mem_hs_cyc[$];

  logic                 prev_mem_stall  = 1'b0;
  logic [63+CNT_BITS:0] prev_mem_pl     = '0;
  logic                 prev_intr_stall = 1'b0;
  t_cmd_intr_id         prev_intr_id    = '0;

  copy_engine_cmpl_notify #(.CNT_BITS(CNT_BITS)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .wr_cmd          (wr_cmd),
    .cmpl_valid      (cmpl_valid),
    .status_wr_valid (status_wr_valid),
    .status_wr_ready (status_wr_ready),
    .status_wr_addr  (status_wr_addr),
    .status_wr_data  (status_wr_data),
    .intr_valid      (intr_valid),
    .intr_ready      (intr_ready),
    .intr_id_out     (intr_id_out),
    .cmds_done       (cmds_done),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard monitor: checks handshakes and payload stability mid-cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_mem_stall  = 1'b0;
      prev_intr_stall = 1'b0;
    end else begin
      if (prev_mem_stall) begin
        checks++;
        if (status_wr_valid !== 1'b1 || {status_wr_addr, status_wr_data} !== prev_mem_pl) begin
          errors++;
          $display("FAIL mem_hold: valid=%b addr=%h data=%0d, required valid=1 payload=%h",
                   status_wr_valid, status_wr_addr, status_wr_data, prev_mem_pl);
        end
      end
      if (prev_intr_stall) begin
        checks++;
        if (intr_valid !== 1'b1 || intr_id_out !== prev_intr_id) begin
          errors++;
          $display("FAIL intr_hold: valid=%b id=%0d, required valid=1 id=%0d",
                   intr_valid, intr_id_out, prev_intr_id);
        end
      end
      if (status_wr_valid && status_wr_ready) begin
        n_mem++;
        mem_hs_cyc.push_back(cyc);
        checks++;
        if (exp_mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected: addr=%h data=%0d, required no write", status_wr_addr, status_wr_data);
        end else begin
          logic [63+CNT_BITS:0] e;
          e = exp_mem_q.pop_front();
          if ({status_wr_addr, status_wr_data} !== e) begin
            errors++;
            $display("FAIL mem_write: addr=%h data=%0d, required addr=%h data=%0d",
                     status_wr_addr, status_wr_data, e[CNT_BITS +: 64], e[CNT_BITS-1:0]);
          end
        end
      end
      if (intr_valid && intr_ready) begin
        n_intr++;
        checks++;
        if (exp_intr_q.size() == 0) begin
          errors++;
          $display("FAIL intr_unexpected: id=%0d, required no interrupt", intr_id_out);
        end else begin
          t_cmd_intr_id e;
          e = exp_intr_q.pop_front();
          if (intr_id_out !== e) begin
            errors++;
            $display("FAIL intr_id: id=%0d, required %0d", intr_id_out, e);
          end
        end
      end
      prev_mem_stall  = status_wr_valid && !status_wr_ready;
      prev_mem_pl     = {status_wr_addr, status_wr_data};
      prev_intr_stall = intr_valid && !intr_ready;
      prev_intr_id    = intr_id_out;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle completion pulse; returns #1 after the edge that counts it.
  task automatic pulse();
    tick(1);
    cmpl_valid = 1'b1;
    tick(1);
    cmpl_valid = 1'b0;
  endtask

  task automatic ack();
    wr_cmd.intr_ack = 1'b1;
    tick(1);
    wr_cmd.intr_ack = 1'b0;
  endtask

  // Select mode and re-enable so the counter starts from zero.
  task automatic set_mode(input logic mem, input t_cmd_intr_id id);
    wr_cmd.use_mem_status  = mem;
    wr_cmd.intr_id         = id;
    wr_cmd.mem_status_addr = 64'h1000;
    wr_cmd.enable          = 1'b0;
    tick(1);
    wr_cmd.enable = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wr_cmd = '0;
    cmpl_valid = 1'b0;
    status_wr_ready = 1'b0;
    intr_ready = 1'b0;
    tick(3);
    checks++;
    if (status_wr_valid !== 1'b0 || intr_valid !== 1'b0 || cmds_done !== '0 || busy !== 1'b0 ||
        status_wr_addr !== '0 || status_wr_data !== '0 || intr_id_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: swv=%b iv=%b done=%0d busy=%b addr=%h data=%0d id=%0d, required all 0",
               status_wr_valid, intr_valid, cmds_done, busy, status_wr_addr, status_wr_data, intr_id_out);
    end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_mem_basic();
    int n0;
    int k;
    n0 = n_mem;
    status_wr_ready = 1'b1;
    set_mode(1'b1, 4'd0);
    for (int i = 1; i <= 3; i++) begin
      exp_mem_q.push_back({64'h1000, 64'(i)});
      pulse();
      if (i == 1) begin
        checks++;
        if (cmds_done !== 64'd1 || status_wr_valid !== 1'b0) begin
          errors++;
          $display("FAIL mem_n1: done=%0d valid=%b, required done=1 valid=0", cmds_done, status_wr_valid);
        end
        tick(1);
        checks++;
        if (status_wr_valid !== 1'b1 || status_wr_data !== 64'd1 || status_wr_addr !== 64'h1000) begin
          errors++;
          $display("FAIL mem_n2: valid=%b addr=%h data=%0d, required valid=1 addr=1000 data=1",
                   status_wr_valid, status_wr_addr, status_wr_data);
        end
      end
      tick(9);
    end
    k = 0;
    while (exp_mem_q.size() != 0 && k < 50) begin tick(1); k++; end
    checks++;
    if (exp_mem_q.size() != 0 || n_mem - n0 != 3 || cmds_done !== 64'd3) begin
      errors++;
      $display("FAIL mem_basic_total: writes=%0d pending=%0d done=%0d, required writes=3 pending=0 done=3",
               n_mem - n0, exp_mem_q.size(), cmds_done);
    end
  endtask

  task automatic test_mem_backpressure();
    int n0;
    int k;
    n0 = n_mem;
    status_wr_ready = 1'b0;
    set_mode(1'b1, 4'd0);
    exp_mem_q.push_back({64'h1000, 64'd1});
    exp_mem_q.push_back({64'h1000, 64'd5});
    for (int i = 0; i < 5; i++) begin
      pulse();
      tick(2);
      if (i == 0) begin
        checks++;
        if (status_wr_valid !== 1'b1 || status_wr_data !== 64'd1) begin
          errors++;
          $display("FAIL bp_first: valid=%b data=%0d, required valid=1 data=1", status_wr_valid, status_wr_data);
        end
      end
    end
    tick(5);
    checks++;
    if (status_wr_valid !== 1'b1 || status_wr_data !== 64'd1 || cmds_done !== 64'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: valid=%b data=%0d done=%0d busy=%b, required valid=1 data=1 done=5 busy=1",
               status_wr_valid, status_wr_data, cmds_done, busy);
    end
    mem_hs_cyc.delete();
    status_wr_ready = 1'b1;
    k = 0;
    while (exp_mem_q.size() != 0 && k < 50) begin tick(1); k++; end
    tick(10);
    checks++;
    if (n_mem - n0 != 2 || exp_mem_q.size() != 0) begin
      errors++;
      $display("FAIL bp_total: writes=%0d pending=%0d, required writes=2 pending=0", n_mem - n0, exp_mem_q.size());
    end
    checks++;
    if (mem_hs_cyc.size() != 2 || mem_hs_cyc[1] - mem_hs_cyc[0] != 2) begin
      errors++;
      $display("FAIL bp_spacing: handshakes=%0d gap=%0d, required handshakes=2 gap=2",
               mem_hs_cyc.size(), (mem_hs_cyc.size() == 2) ? mem_hs_cyc[1] - mem_hs_cyc[0] : -1);
    end
  endtask

  task automatic test_intr();
    int n0;
    n0 = n_intr;
    intr_ready = 1'b1;
    set_mode(1'b0, 4'd2);
    exp_intr_q.push_back(4'd2);
    pulse();
    checks++;
    if (intr_valid !== 1'b0 || cmds_done !== 64'd1) begin
      errors++;
      $display("FAIL intr_n1: valid=%b done=%0d, required valid=0 done=1", intr_valid, cmds_done);
    end
    tick(1);
    checks++;
    if (intr_valid !== 1'b1 || intr_id_out !== 4'd2) begin
      errors++;
      $display("FAIL intr_n2: valid=%b id=%0d, required valid=1 id=2", intr_valid, intr_id_out);
    end
    for (int i = 0; i < 3; i++) pulse();
    tick(8);
    checks++;
    if (n_intr - n0 != 1 || busy !== 1'b1 || intr_valid !== 1'b0) begin
      errors++;
      $display("FAIL intr_coalesce: irqs=%0d busy=%b valid=%b, required irqs=1 busy=1 valid=0",
               n_intr - n0, busy, intr_valid);
    end
    exp_intr_q.push_back(4'd2);
    ack();
    tick(6);
    ack();
    tick(6);
    checks++;
    if (n_intr - n0 != 2 || exp_intr_q.size() != 0 || busy !== 1'b0 || cmds_done !== 64'd4) begin
      errors++;
      $display("FAIL intr_after_ack: irqs=%0d pending=%0d busy=%b done=%0d, required irqs=2 pending=0 busy=0 done=4",
               n_intr - n0, exp_intr_q.size(), busy, cmds_done);
    end
  endtask

  task automatic test_ack_idle();
    int n0;
    n0 = n_intr;
    ack();
    tick(5);
    checks++;
    if (n_intr != n0 || busy !== 1'b0 || intr_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle: irqs=%0d busy=%b valid=%b, required irqs=0 busy=0 valid=0",
               n_intr - n0, busy, intr_valid);
    end
    exp_intr_q.push_back(4'd2);
    pulse();
    tick(4);
    checks++;
    if (n_intr - n0 != 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ack_idle_later: irqs=%0d busy=%b, required irqs=1 busy=1", n_intr - n0, busy);
    end
    ack();
    tick(2);
  endtask

  task automatic test_enable_drop();
    int n0;
    set_mode(1'b0, 4'd7);
    n0 = n_intr;
    exp_intr_q.push_back(4'd7);
    pulse();
    tick(4);
    checks++;
    if (busy !== 1'b1 || n_intr - n0 != 1) begin
      errors++;
      $display("FAIL en_wait: busy=%b irqs=%0d, required busy=1 irqs=1", busy, n_intr - n0);
    end
    wr_cmd.enable = 1'b0;
    tick(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL en_drop_idle: busy=%b, required 0", busy);
    end
    wr_cmd.enable = 1'b1;
    tick(1);
    checks++;
    if (cmds_done !== '0) begin
      errors++;
      $display("FAIL en_clear: done=%0d, required 0", cmds_done);
    end
    tick(10);
    checks++;
    if (n_intr - n0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL en_quiet: irqs=%0d busy=%b, required irqs=1 busy=0", n_intr - n0, busy);
    end
  endtask

  task automatic test_async_reset();
    int n0;
    n0 = n_mem;
    status_wr_ready = 1'b0;
    set_mode(1'b1, 4'd0);
    pulse();
    tick(1);
    checks++;
    if (status_wr_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: valid=%b busy=%b, required valid=1 busy=1", status_wr_valid, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (status_wr_valid !== 1'b0 || cmds_done !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: valid=%b done=%0d busy=%b, required valid=0 done=0 busy=0",
               status_wr_valid, cmds_done, busy);
    end
    status_wr_ready = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(10);
    checks++;
    if (n_mem != n0 || status_wr_valid !== 1'b0 || cmds_done !== '0) begin
      errors++;
      $display("FAIL rst_after: writes=%0d valid=%b done=%0d, required writes=0 valid=0 done=0",
               n_mem - n0, status_wr_valid, cmds_done);
    end
  endtask

  initial begin
    test_reset();
    test_mem_basic();
    test_mem_backpressure();
    test_intr();
    test_ack_idle();
    test_enable_drop();
    test_async_reset();
    checks++;
    if (exp_mem_q.size() != 0 || exp_intr_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: mem_pending=%0d intr_pending=%0d, required 0 and 0",
               exp_mem_q.size(), exp_intr_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
